// File: rtl/int_source_ctrl_if.sv
// Configuration port of the interrupt source controller: write strobe/address/data
// plus a combinational read port.
interface int_source_ctrl_if #(
    parameter int TWIDTH = 16
);
    logic              we;
    logic [1:0]        waddr;
    logic [TWIDTH-1:0] wdata;
    logic [1:0]        raddr;
    logic [TWIDTH-1:0] rdata;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata
    );
endinterface

// File: rtl/int_source_ctrl.sv
// Interrupt front end: synchronizes external lines, qualifies edge/level, masks,
// and merges a periodic/one-shot timer request onto TIMER_LINE.
//
// Timer FSM
//   state  | meaning
//   T_IDLE | timer stopped, counter holds its value
//   T_RUN  | counting down; an event issues on the cycle counter == 1
module int_source_ctrl #(
    parameter int WIDTH      = 8,
    parameter int TWIDTH     = 16,
    parameter int TIMER_LINE = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    int_raw,
    int_source_ctrl_if.slave    cfg,
    output logic [WIDTH-1:0]    int_e
);

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } tstate_t;

    tstate_t           state;
    tstate_t           state_nxt;

    logic [WIDTH-1:0]  sync1;
    logic [WIDTH-1:0]  sync2;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  mask;
    logic [WIDTH-1:0]  mode;
    logic [TWIDTH-1:0] period;
    logic [TWIDTH-1:0] counter;
    logic              autoreload;
    logic              done;

    logic              ctrl_wr;
    logic              timer_evt;
    logic              cnt_at_one;
    logic [WIDTH-1:0]  ext_evt;
    logic [WIDTH-1:0]  timer_vec;

    assign ctrl_wr    = cfg.we && (cfg.waddr == 2'd3);
    assign cnt_at_one = (counter == TWIDTH'(1));

    // Level lines pass sync2 straight through; edge lines fire only on a 0->1 step.
    assign ext_evt = (mode & sync2) | (~mode & sync2 & ~prev);

    always_comb begin
        timer_vec             = '0;
        timer_vec[TIMER_LINE] = timer_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            prev   <= '0;
            int_e  <= '0;
            mask   <= '0;
            mode   <= '0;
            period <= '0;
        end else begin
            sync1 <= int_raw;
            sync2 <= sync1;
            prev  <= sync2;
            int_e <= mask & (ext_evt | timer_vec);
            if (cfg.we) begin
                case (cfg.waddr)
                    2'd0:    mask   <= cfg.wdata[WIDTH-1:0];
                    2'd1:    mode   <= cfg.wdata[WIDTH-1:0];
                    2'd2:    period <= cfg.wdata;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= T_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A ctrl write always overrides the expiry decision taken in the same cycle.
    always_comb begin
        state_nxt = state;
        if (ctrl_wr) begin
            state_nxt = cfg.wdata[0] ? T_RUN : T_IDLE;
        end else if (state == T_RUN && cnt_at_one && !autoreload) begin
            state_nxt = T_IDLE;
        end
    end

    always_comb begin
        timer_evt = (state == T_RUN) && cnt_at_one;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
        end else if (ctrl_wr) begin
            if (cfg.wdata[0]) begin
                counter <= period;
            end
        end else if (state == T_RUN) begin
            if (cnt_at_one) begin
                if (autoreload) begin
                    counter <= period;
                end
            end else if (counter > TWIDTH'(1)) begin
                counter <= counter - TWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            autoreload <= 1'b0;
            done       <= 1'b0;
        end else if (ctrl_wr) begin
            autoreload <= cfg.wdata[1];
            done       <= 1'b0;
        end else if (timer_evt && !autoreload) begin
            done <= 1'b1;
        end
    end

    always_comb begin
        cfg.rdata = '0;
        case (cfg.raddr)
            2'd0:    cfg.rdata[WIDTH-1:0] = mask;
            2'd1:    cfg.rdata[WIDTH-1:0] = mode;
            2'd2:    cfg.rdata            = period;
            default: cfg.rdata[2:0]       = {done, autoreload, (state == T_RUN)};
        endcase
    end

endmodule

// File: tb/tb_int_source_ctrl.sv
// Self-checking bench for int_source_ctrl: register table, directed corner sequences,
// and a randomized run against a cycle-indexed reference model.
module tb_int_source_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  int_raw = '0;
    logic [7:0]  int_e;

    int n_checks = 0;
    int n_pass   = 0;

    int_source_ctrl_if #(.TWIDTH(16)) cfg_bus ();

    int_source_ctrl #(.WIDTH(8), .TWIDTH(16), .TIMER_LINE(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .int_raw (int_raw),
        .cfg     (cfg_bus),
        .int_e   (int_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the raw line value seen at each past edge, and the timer
    // expressed as the absolute edge number on which its next request appears.
    int          edge_no = 0;
    int          fire_at = -1;
    logic [7:0]  m_mask = '0, m_mode = '0, m_int_e = '0;
    logic [15:0] m_period = '0;
    bit          m_en = 0, m_ar = 0, m_done = 0;
    logic [7:0]  raw_d1 = '0, raw_d2 = '0, raw_d3 = '0;

    function automatic logic [15:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, m_mask};
            2'd1:    return {8'h00, m_mode};
            2'd2:    return m_period;
            default: return {13'h0, m_done, m_ar, m_en};
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] ev;
        bit         tevt;
        if (reset) begin
            m_mask = '0; m_mode = '0; m_period = '0; m_int_e = '0;
            m_en = 0; m_ar = 0; m_done = 0; fire_at = -1;
            raw_d1 = '0; raw_d2 = '0; raw_d3 = '0;
        end else begin
            ev      = (m_mode & raw_d2) | (~m_mode & raw_d2 & ~raw_d3);
            tevt    = m_en && (fire_at == edge_no);
            m_int_e = m_mask & (ev | (tevt ? 8'h80 : 8'h00));
            if (tevt) begin
                if (m_ar) fire_at = (m_period == 0) ? -1 : edge_no + int'(m_period);
                else begin m_en = 0; m_done = 1; end
            end
            if (cfg_bus.we) begin
                case (cfg_bus.waddr)
                    2'd0: m_mask   = cfg_bus.wdata[7:0];
                    2'd1: m_mode   = cfg_bus.wdata[7:0];
                    2'd2: m_period = cfg_bus.wdata;
                    default: begin
                        m_en   = cfg_bus.wdata[0];
                        m_ar   = cfg_bus.wdata[1];
                        m_done = 0;
                        if (cfg_bus.wdata[0])
                            fire_at = (m_period == 0) ? -1 : edge_no + int'(m_period);
                    end
                endcase
            end
            raw_d3 = raw_d2; raw_d2 = raw_d1; raw_d1 = int_raw;
        end
        edge_no++;
    endtask

    always begin
        @(posedge clk);
        model_edge();
        #1;
        chk("int_e_model", {8'h00, int_e}, {8'h00, m_int_e});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_bus.we = 1'b1; cfg_bus.waddr = a; cfg_bus.wdata = d;
        tick(1);
        cfg_bus.we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t    tbl[8];
    logic [15:0] old_val[4];

    initial begin
        tbl[0] = '{2'd0, 16'h01FF, 16'h00FF};
        tbl[1] = '{2'd1, 16'hABCD, 16'h00CD};
        tbl[2] = '{2'd2, 16'hBEEF, 16'hBEEF};
        tbl[3] = '{2'd3, 16'hFFF8, 16'h0000};
        tbl[4] = '{2'd3, 16'h0006, 16'h0002};
        tbl[5] = '{2'd0, 16'h0000, 16'h0000};
        tbl[6] = '{2'd1, 16'h0000, 16'h0000};
        tbl[7] = '{2'd3, 16'h0000, 16'h0000};

        cfg_bus.we = 1'b0; cfg_bus.waddr = '0; cfg_bus.wdata = '0; cfg_bus.raddr = '0;
        tick(2);
        chk("reset_int_e", {8'h00, int_e}, 16'h0000);
        for (int a = 0; a < 4; a++) begin
            cfg_bus.raddr = 2'(a);
            #1;
            chk("reset_rdata", cfg_bus.rdata, 16'h0000);
            old_val[a] = 16'h0000;
        end
        reset = 1'b0;
        tick(1);

        // Register table: same-address read during a write returns the old value.
        for (int i = 0; i < 8; i++) begin
            cfg_bus.we = 1'b1; cfg_bus.waddr = tbl[i].addr; cfg_bus.wdata = tbl[i].data;
            cfg_bus.raddr = tbl[i].addr;
            #1;
            chk("rd_during_wr", cfg_bus.rdata, old_val[tbl[i].addr]);
            tick(1);
            cfg_bus.we = 1'b0;
            #1;
            chk("rd_after_wr", cfg_bus.rdata, tbl[i].exp);
            old_val[tbl[i].addr] = tbl[i].exp;
        end

        // Edge path
        do_reset();
        wr(2'd0, 16'h00FF); wr(2'd1, 16'h0000);
        int_raw = 8'h04;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("edge_pulse", {8'h00, int_e}, (i == 2) ? 16'h0004 : 16'h0000);
        end
        int_raw = 8'h00; tick(4);

        // Mask: masked events are dropped, late unmask produces nothing
        wr(2'd0, 16'h00FD);
        int_raw = 8'h02;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("masked_line1", {8'h00, int_e}, 16'h0000);
        end
        int_raw = 8'h03;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("unmasked_line0", {8'h00, int_e}, (i == 2) ? 16'h0001 : 16'h0000);
        end
        wr(2'd0, 16'h00FF);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("no_late_evt", {8'h00, int_e}, 16'h0000);
        end
        int_raw = 8'h00; tick(4);

        // Level mode
        wr(2'd1, 16'h0008);
        int_raw = 8'h08;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) int_raw = 8'h00;
            tick(1);
            chk("level_line3", {8'h00, int_e}, (i >= 2 && i <= 6) ? 16'h0008 : 16'h0000);
        end
        wr(2'd1, 16'h0000);

        // Periodic timer, then stop
        wr(2'd2, 16'd5); wr(2'd3, 16'h0003);
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            chk("periodic", {8'h00, int_e}, (i % 5 == 0) ? 16'h0080 : 16'h0000);
        end
        wr(2'd3, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("stopped", {8'h00, int_e}, 16'h0000);
        end

        // One-shot with done flag
        wr(2'd2, 16'd3); wr(2'd3, 16'h0001);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk("one_shot", {8'h00, int_e}, (i == 3) ? 16'h0080 : 16'h0000);
        end
        cfg_bus.raddr = 2'd3; #1;
        chk("done_set", cfg_bus.rdata, 16'h0004);
        wr(2'd3, 16'h0000); #1;
        chk("done_clr", cfg_bus.rdata, 16'h0000);

        // Ctrl write on the expiry cycle: event still issues, write wins
        wr(2'd2, 16'd4); wr(2'd3, 16'h0003);
        tick(3);
        wr(2'd3, 16'h0001);
        chk("collide_evt", {8'h00, int_e}, 16'h0080);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk("collide_after", {8'h00, int_e}, (i == 4) ? 16'h0080 : 16'h0000);
        end
        cfg_bus.raddr = 2'd3; #1;
        chk("collide_done", cfg_bus.rdata, 16'h0004);
        wr(2'd3, 16'h0000);

        // Period zero: enabled but silent
        wr(2'd2, 16'd0); wr(2'd3, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("period_zero", {8'h00, int_e}, 16'h0000);
        end
        cfg_bus.raddr = 2'd3; #1;
        chk("period_zero_en", cfg_bus.rdata, 16'h0001);
        wr(2'd3, 16'h0000);

        // Reset mid-count with line 0 held high
        wr(2'd2, 16'd10); wr(2'd3, 16'h0003);
        tick(3);
        int_raw = 8'h01;
        reset = 1'b1;
        tick(1);
        chk("rst_int_e", {8'h00, int_e}, 16'h0000);
        for (int a = 0; a < 4; a++) begin
            cfg_bus.raddr = 2'(a); #1;
            chk("rst_rdata", cfg_bus.rdata, 16'h0000);
        end
        tick(1);
        reset = 1'b0;
        wr(2'd0, 16'h00FF);
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            chk("post_rst_edge", {8'h00, int_e}, (i == 2) ? 16'h0001 : 16'h0000);
        end
        int_raw = 8'h00; tick(3);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) int_raw = int_raw ^ (8'($urandom) & 8'($urandom));
            cfg_bus.we    = ($urandom_range(0, 3) == 0);
            cfg_bus.waddr = 2'($urandom_range(0, 3));
            if (cfg_bus.waddr >= 2'd2) cfg_bus.wdata = 16'($urandom_range(0, 7));
            else                       cfg_bus.wdata = 16'($urandom);
            cfg_bus.raddr = 2'($urandom_range(0, 3));
            #1;
            chk("rd_rand", cfg_bus.rdata, model_rd(cfg_bus.raddr));
            tick(1);
        end
        reset = 1'b0; cfg_bus.we = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
